// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: wait states, byte/half/word write strobes, two-cycle ERROR.
// Define AHB_SRAM_ERR_CHECK_EN to enable illegal-transfer detection and the ERR1/ERR2 states.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [2:0] WS_M1 = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

`ifdef AHB_SRAM_ERR_CHECK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;
`endif

  state_t                  r_state;
  state_t                  w_state_next;
  state_t                  w_acc_state;
  logic [2:0]              r_cnt;
  logic                    r_valid;
  logic                    r_write;
  logic [IDX_W-1:0]        r_idx;
  logic [3:0]              r_be;
  logic                    r_hreadyout;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
  logic                    w_accept;
  logic                    w_take;
  logic                    w_illegal;
  logic                    w_commit;
  logic [3:0]              w_be;
  logic                    w_unused;

  assign w_accept = hselx & hready & htrans[1];
  assign w_unused = ^{hburst, hprot, hmastlock, haddr};

`ifdef AHB_SRAM_ERR_CHECK_EN
  logic r_hresp;
  assign w_illegal = (hsize > 3'b010)
                   || ((hsize == 3'b001) && haddr[0])
                   || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                   || (haddr[ADDR_WIDTH-1:IDX_W+2] != '0);
  assign w_acc_state = w_illegal ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
  assign hresp = r_hresp;
`else
  // Without checking, upper index bits wrap and misaligned lanes fall back to the aligned ones.
  assign w_illegal = 1'b0;
  assign w_acc_state = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
  assign hresp = 1'b0;
`endif

  always_comb begin
    w_be = 4'b1111;
    case (hsize)
      3'b000:  w_be = 4'b0001 << haddr[1:0];
      3'b001:  w_be = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (r_state)
      ST_IDLE, ST_DATA: w_take = w_accept;
`ifdef AHB_SRAM_ERR_CHECK_EN
      ST_ERR2:          w_take = w_accept;
`endif
      default:          w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DATA: w_state_next = w_take ? w_acc_state : ST_IDLE;
      ST_WAIT:          w_state_next = (r_cnt == 3'd0) ? ST_DATA : ST_WAIT;
`ifdef AHB_SRAM_ERR_CHECK_EN
      ST_ERR1:          w_state_next = ST_ERR2;
      ST_ERR2:          w_state_next = w_take ? w_acc_state : ST_IDLE;
`endif
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_be        <= 4'b0000;
      r_hreadyout <= 1'b1;
`ifdef AHB_SRAM_ERR_CHECK_EN
      r_hresp     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
`ifdef AHB_SRAM_ERR_CHECK_EN
      r_hreadyout <= (w_state_next != ST_WAIT) && (w_state_next != ST_ERR1);
      r_hresp     <= (w_state_next == ST_ERR1) || (w_state_next == ST_ERR2);
`else
      r_hreadyout <= (w_state_next != ST_WAIT);
`endif
      // Data-phase registers only load on acceptance, so they hold across wait cycles.
      if (w_take) begin
        r_write <= hwrite;
        r_idx   <= haddr[IDX_W+1:2];
        r_be    <= w_be;
        r_valid <= ~w_illegal;
      end else if (r_state == ST_DATA) begin
        r_valid <= 1'b0;
      end
      if (w_take && (w_acc_state == ST_WAIT)) begin
        r_cnt <= WS_M1;
      end else if ((r_state == ST_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  assign w_commit = (r_state == ST_DATA) && r_valid && r_write;

  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][i*8 +: 8] <= hwdata[i*8 +: 8];
        end
      end
    end
  end

  assign hreadyout = r_hreadyout;
  assign hrdata    = ((r_state == ST_DATA) && !r_write) ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one zero-wait and one three-wait instance share the bus.
module tb_ahb_sram_slave;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          resp;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyout0, hresp0, hreadyout3, hresp3;
  logic [31:0] hrdata0, hrdata3;
  logic        m_ready, m_resp;
  logic [31:0] m_rdata;
  bit          sel3;
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;

  always #5 hclk = ~hclk;

  assign m_ready = sel3 ? hreadyout3 : hreadyout0;
  assign m_resp  = sel3 ? hresp3 : hresp0;
  assign m_rdata = sel3 ? hrdata3 : hrdata0;

  ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel & ~sel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hreadyout0), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel & sel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hreadyout3), .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Address phase plus pushed expectation; returns one step after acceptance with hwdata driven.
  task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                       input logic [31:0] ed, input bit er, input int ew);
    exp_t e;
    bit   ok;
    int   n;
    e.rd = ~w; e.data = ed; e.resp = er; e.waits = ew;
    sb.push_back(e);
    $display("xfer dut=ws%0d %s addr=%h size=%0d wdata=%h exp_rdata=%h exp_resp=%0d exp_waits=%0d",
             sel3 ? 3 : 0, w ? "WR" : "RD", a, sz, wd, ed, er, ew);
    hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz;
    n = 0;
    forever begin
      @(negedge hclk);
      ok = m_ready;
      @(posedge hclk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", {31'b0, ok}, 32'h1);
        break;
      end
    end
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  initial begin : monitor
    exp_t cur;
    bit   dp;
    int   waits;
    dp = 0;
    waits = 0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        dp = 0;
        continue;
      end
      if (dp) begin
        if (!m_ready) begin
          waits++;
          check("wait_hrdata", m_rdata, 32'h0);
          if (cur.resp) check("err1_hresp", {31'b0, m_resp}, 32'h1);
        end else begin
          check("waits", 32'(waits), 32'(cur.waits));
          check("hresp", {31'b0, m_resp}, {31'b0, cur.resp});
          if (cur.rd) check("hrdata", m_rdata, cur.data);
          dp = 0;
        end
      end
      if (hsel && m_ready && htrans[1]) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'h1);
        end else begin
          cur = sb.pop_front();
          dp = 1;
          waits = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; sel3 = 0;
    idle(3);
    hresetn = 1'b1;
    #1;
    check("rst_hreadyout0", {31'b0, hreadyout0}, 32'h1);
    check("rst_hresp0", {31'b0, hresp0}, 32'h0);
    check("rst_hrdata0", hrdata0, 32'h0);
    check("rst_hreadyout3", {31'b0, hreadyout3}, 32'h1);
    check("rst_hresp3", {31'b0, hresp3}, 32'h0);
    idle(2);

    // Zero-wait back-to-back write then read of the same word.
    issue(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, 0);
    issue(0, 32'h10, 3'b010, 32'h99999999, 32'hDEADBEEF, 0, 0);
    // Byte and halfword strobes; other lanes of hwdata carry junk.
    issue(1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0, 0);
    issue(1, 32'h21, 3'b000, 32'hFFFFAAFF, 32'h0, 0, 0);
    issue(1, 32'h22, 3'b001, 32'hBBCC1234, 32'h0, 0, 0);
    issue(0, 32'h20, 3'b010, 32'h99999999, 32'hBBCCAA44, 0, 0);
    idle(2);

`ifdef AHB_SRAM_ERR_CHECK_EN
    issue(1, 32'h0, 3'b010, 32'h0BADC0DE, 32'h0, 0, 0);
    issue(1, 32'h2, 3'b010, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(0, 32'h0, 3'b010, 32'h99999999, 32'h0BADC0DE, 0, 0);
    issue(1, 32'h1000, 3'b010, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(1, 32'h1, 3'b001, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(1, 32'h0, 3'b011, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(0, 32'h0, 3'b010, 32'h99999999, 32'h0BADC0DE, 0, 0);
`else
    issue(1, 32'h1000, 3'b010, 32'h00000055, 32'h0, 0, 0);
    issue(0, 32'h0, 3'b010, 32'h99999999, 32'h00000055, 0, 0);
    issue(1, 32'h32, 3'b010, 32'hA5A5A5A5, 32'h0, 0, 0);
    issue(1, 32'h31, 3'b001, 32'h12347777, 32'h0, 0, 0);
    issue(0, 32'h30, 3'b010, 32'h99999999, 32'hA5A57777, 0, 0);
    issue(1, 32'h34, 3'b011, 32'h01020304, 32'h0, 0, 0);
    issue(0, 32'h34, 3'b010, 32'h99999999, 32'h01020304, 0, 0);
`endif
    idle(3);

    // Three wait states.
    sel3 = 1;
    issue(1, 32'h40, 3'b010, 32'hCAFEF00D, 32'h0, 0, 3);
    issue(1, 32'h48, 3'b010, 32'h600DD00D, 32'h0, 0, 3);
    issue(0, 32'h40, 3'b010, 32'h99999999, 32'hCAFEF00D, 0, 3);
    // A NONSEQ write shown only while hready is low must be ignored.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h48; hsize = 3'b010;
    idle(2);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    idle(4);
    issue(0, 32'h48, 3'b010, 32'h99999999, 32'h600DD00D, 0, 3);
`ifdef AHB_SRAM_ERR_CHECK_EN
    issue(1, 32'h1000, 3'b010, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(0, 32'h40, 3'b010, 32'h99999999, 32'hCAFEF00D, 0, 3);
`endif
    idle(6);

    // Reset during a wait cycle discards the pending write.
    issue(1, 32'h40, 3'b010, 32'h12345678, 32'h0, 0, 3);
    @(posedge hclk);
    #1;
    check("ws3_wait_low", {31'b0, hreadyout3}, 32'h0);
    #1;
    hresetn = 1'b0;
    #1;
    check("async_rst_hreadyout", {31'b0, hreadyout3}, 32'h1);
    check("async_rst_hresp", {31'b0, hresp3}, 32'h0);
    check("async_rst_hrdata", hrdata3, 32'h0);
    sb.delete();
    idle(2);
    hresetn = 1'b1;
    idle(1);
    issue(0, 32'h40, 3'b010, 32'h99999999, 32'hCAFEF00D, 0, 3);
    idle(8);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
